// File: rtl/bin_to_bcd_converter_if.sv
// Request/result bundle for bin_to_bcd_converter: start and bin_in go in,
// busy, done, packed BCD and sign come back.
interface bin_to_bcd_converter_if #(
   parameter int WORD_LENGTH = 16,
   parameter int BCD_DIGITS  = 5
);
   logic                      start;
   logic [WORD_LENGTH-1:0]    bin_in;
   logic                      busy;
   logic                      done;
   logic [4*BCD_DIGITS-1:0]   bcd_out;
   logic                      sign;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, sign
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, sign
   );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional macro BCD_SIGNED_EN: treat bin_in as two's complement and report sign.
module bin_to_bcd_converter #(
   parameter int WORD_LENGTH = 16,
   parameter int BCD_DIGITS  = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   bin_to_bcd_converter_if.slave      bus,
   output logic [1:0]                 state_o
);

   // Handshake: start is sampled only while IDLE; the accepting edge also
   // samples bin_in and raises busy. busy stays high until the edge that
   // raises done for exactly one cycle, on which bcd_out/sign update. A start
   // seen while busy or finishing is dropped, never queued.

   localparam int BCD_W = 4 * BCD_DIGITS;
   localparam int CNT_W = $clog2(WORD_LENGTH + 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WORD_LENGTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [WORD_LENGTH-1:0] shift_q, shift_d;
   logic [BCD_W-1:0]       scratch_q, scratch_d;
   logic [BCD_W-1:0]       scratch_adj;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [BCD_W-1:0]       bcd_q, bcd_d;
   logic [WORD_LENGTH-1:0] load_val;

`ifdef BCD_SIGNED_EN
   logic sign_cap_q, sign_cap_d;
   logic sign_q, sign_d;

   // Negation in WORD_LENGTH bits maps the most-negative value onto itself,
   // which read as unsigned is exactly its magnitude.
   assign load_val = bus.bin_in[WORD_LENGTH-1] ? (WORD_LENGTH'(0) - bus.bin_in)
                                               : bus.bin_in;

   always_comb begin
      sign_cap_d = sign_cap_q;
      sign_d     = sign_q;
      if (state_q == IDLE && bus.start) sign_cap_d = bus.bin_in[WORD_LENGTH-1];
      if (state_q == FINISH)            sign_d     = sign_cap_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sign_cap_q <= 1'b0;
         sign_q     <= 1'b0;
      end else begin
         sign_cap_q <= sign_cap_d;
         sign_q     <= sign_d;
      end
   end

   assign bus.sign = sign_q;
`else
   assign load_val = bus.bin_in;
   assign bus.sign = 1'b0;
`endif

   always_comb begin
      scratch_adj = scratch_q;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d   = load_val;
               scratch_d = '0;
               cnt_d     = CNT_INIT;
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            {scratch_d, shift_d} = {scratch_adj, shift_q} << 1;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) state_d = FINISH;
         end
         FINISH: begin
            bcd_d   = scratch_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.bcd_out = bcd_q;
   assign state_o     = state_q;

endmodule
